// File: rtl/mfp_pkg.sv
// Shared definitions for the MFP serial-out SPI slave: command code and FSM states.
package mfp_pkg;
  localparam logic [7:0] CMD_SER_OUT_DEFAULT = 8'h1a;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    STATUS,
    DATA,
    IGNORE
  } state_t;
endpackage

// File: rtl/mfp_serial_spi_if.sv
// SPI pins plus the MFP transmit-FIFO consumer signals, bundled as one bus.
interface mfp_serial_spi_if;
  logic       spi_sck;
  logic       spi_ss_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       serial_data_out_available;
  logic [7:0] serial_data_out;
  logic       serial_strobe_out;

  modport slave (
    input  spi_sck, spi_ss_n, spi_mosi, serial_data_out_available, serial_data_out,
    output spi_miso, serial_strobe_out
  );

  modport master (
    output spi_sck, spi_ss_n, spi_mosi, serial_data_out_available, serial_data_out,
    input  spi_miso, serial_strobe_out
  );
endinterface

// File: rtl/mfp_serial_spi_sync.sv
// Synchronizes the SPI pins into clk and derives one-cycle sck edge pulses.
module mfp_serial_spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sck,
  input  logic ss_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_n_s,
  output logic mosi_s
);
  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sck_d;

  // ss_n chain resets to deselected so nothing looks like a transaction start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_q  <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
      sck_d  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_d  <= sck_q[SYNC_STAGES-1];
    end
  end

  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_d;
  assign ss_n_s   = ss_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
endmodule

// File: rtl/mfp_serial_spi.sv
// SPI slave that lets the IO controller read one MFP FIFO byte per transaction
// and pops it with a fixed-length strobe once the data byte has fully shifted out.
module mfp_serial_spi
  import mfp_pkg::*;
#(
  parameter logic [7:0] CMD_SER_OUT = CMD_SER_OUT_DEFAULT,
  parameter int         STROBE_LEN  = 4,
  parameter int         SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              reset_n,
  mfp_serial_spi_if.slave  bus
);
  localparam int CNT_W = $clog2(STROBE_LEN + 1);

  logic             sck_rise;
  logic             sck_fall;
  logic             ss_n_s;
  logic             mosi_s;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx;
  logic [7:0]       tx;
  logic [7:0]       rx_full;
  logic             avail_q;
  logic             byte_done;
  logic             strobe_start;
  logic             strobe_pend;
  logic             strobe;
  logic [CNT_W-1:0] strobe_cnt;
  state_t           state;
  state_t           state_next;

  mfp_serial_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .sck      (bus.spi_sck),
    .ss_n     (bus.spi_ss_n),
    .mosi     (bus.spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_n_s   (ss_n_s),
    .mosi_s   (mosi_s)
  );

  // byte_done is not gated by ss_n so a completing byte wins over a same-cycle deselect
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign rx_full   = {rx[6:0], mosi_s};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    strobe_start = 1'b0;
    case (state)
      IDLE:    if (!ss_n_s) state_next = CMD;
      CMD:     if (byte_done) state_next = (rx_full == CMD_SER_OUT) ? STATUS : IGNORE;
               else if (ss_n_s) state_next = IDLE;
      STATUS:  if (byte_done) state_next = DATA;
               else if (ss_n_s) state_next = IDLE;
      DATA: begin
        if (byte_done) begin
          state_next   = IGNORE;
          strobe_start = avail_q;
        end else if (ss_n_s) begin
          state_next = IDLE;
        end
      end
      IGNORE:  if (ss_n_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= 3'd0;
      rx      <= 8'h00;
      tx      <= 8'h00;
      avail_q <= 1'b0;
    end else begin
      if (ss_n_s)        bit_cnt <= 3'd0;
      else if (sck_rise) bit_cnt <= bit_cnt + 3'd1;
      if (!ss_n_s && sck_rise) rx <= rx_full;
      // Loads are snapshots; the fall right after a load (count back at 0) must not shift
      if (state == IDLE && !ss_n_s) begin
        tx <= 8'h00;
      end else if (byte_done) begin
        case (state)
          CMD: begin
            if (rx_full == CMD_SER_OUT) begin
              avail_q <= bus.serial_data_out_available;
              tx      <= {bus.serial_data_out_available, 7'b0};
            end else begin
              tx <= 8'h00;
            end
          end
          STATUS:  tx <= avail_q ? bus.serial_data_out : 8'h00;
          default: tx <= 8'h00;
        endcase
      end else if (sck_fall && !ss_n_s && bit_cnt != 3'd0) begin
        tx <= {tx[6:0], 1'b0};
      end
    end
  end

  // A request arriving while a strobe runs is held until it ends
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_cnt  <= '0;
      strobe      <= 1'b0;
      strobe_pend <= 1'b0;
    end else if (strobe_cnt == '0 && (strobe_start || strobe_pend)) begin
      strobe_cnt  <= CNT_W'(STROBE_LEN);
      strobe      <= 1'b1;
      strobe_pend <= 1'b0;
    end else begin
      if (strobe_start) strobe_pend <= 1'b1;
      if (strobe_cnt != '0) begin
        strobe_cnt <= strobe_cnt - 1'b1;
        strobe     <= (strobe_cnt != CNT_W'(1));
      end
    end
  end

  assign bus.serial_strobe_out = strobe;
  assign bus.spi_miso = (!ss_n_s && (state == CMD || state == STATUS || state == DATA)) ? tx[7] : 1'b0;
endmodule

// File: tb/tb_mfp_serial_spi.sv
// Bench for mfp_serial_spi: SPI master driver, 16-deep MFP FIFO model and a
// transaction-level reference model of what the IO controller should read back.
module tb_mfp_serial_spi;
  import mfp_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  mfp_serial_spi_if bus ();

  mfp_serial_spi #(.CMD_SER_OUT(8'h1a), .STROBE_LEN(4), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #16 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // FIFO model: bench owns the write side, the strobe monitor owns the read side
  logic [7:0] mem [16];
  logic [4:0] wr_ptr = 5'd0;
  logic [4:0] rd_ptr = 5'd0;
  logic [7:0] exp_q [$];

  assign bus.serial_data_out_available = (wr_ptr != rd_ptr);
  assign bus.serial_data_out           = mem[rd_ptr[3:0]];

  int   n_strobe = 0;
  int   cur_len = 0;
  int   last_len = 0;
  int   low_cnt = 0;
  int   last_gap = 0;
  logic strobe_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.serial_strobe_out && !strobe_prev) begin
      rd_ptr   <= rd_ptr + 5'd1;
      n_strobe <= n_strobe + 1;
      cur_len  <= 1;
      last_gap <= low_cnt;
    end else if (bus.serial_strobe_out) begin
      cur_len <= cur_len + 1;
    end else if (strobe_prev) begin
      last_len <= cur_len;
      low_cnt  <= 1;
    end else begin
      low_cnt <= low_cnt + 1;
    end
    strobe_prev <= bus.serial_strobe_out;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 5'd1;
    exp_q.push_back(b);
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = b[7-i];
      half();
      r[7-i] = bus.spi_miso;
      bus.spi_sck = 1'b1;
      half();
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic xact(input logic [7:0] b0, b1, b2, input int nb2,
                      output logic [7:0] r0, r1, r2);
    bus.spi_ss_n = 1'b0;
    half();
    spi_byte(b0, 8, r0);
    spi_byte(b1, 8, r1);
    spi_byte(b2, nb2, r2);
    half();
    bus.spi_ss_n = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  // What the IO controller should see, decided purely from the command and FIFO contents
  function automatic void model(input logic [7:0] cmd, input int nb2,
                                output logic [7:0] e0, e1, e2, output int pop);
    bit hit;
    bit av;
    hit = (cmd == 8'h1a);
    av  = (exp_q.size() != 0);
    e0  = 8'h00;
    e1  = (hit && av) ? 8'h80 : 8'h00;
    e2  = (hit && av) ? exp_q[0] : 8'h00;
    pop = (hit && av && nb2 == 8) ? 1 : 0;
  endfunction

  initial begin
    logic [7:0] r0, r1, r2, e0, e1, e2, cmd, b1, b2;
    int s0, p0, pop, nb2, npush;
    bit seen;

    bus.spi_sck  = 1'b0;
    bus.spi_ss_n = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_miso", 32'(bus.spi_miso), 32'd0);
    chk("reset_strobe", 32'(bus.serial_strobe_out), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Scenario 1: one byte available
    push(8'h41);
    s0 = n_strobe;
    xact(8'h1a, 8'h00, 8'h00, 8, r0, r1, r2);
    void'(exp_q.pop_front());
    chk("s1_b0", 32'(r0), 32'h00);
    chk("s1_b1", 32'(r1), 32'h80);
    chk("s1_b2", 32'(r2), 32'h41);
    chk("s1_strobes", 32'(n_strobe - s0), 32'd1);
    chk("s1_len", 32'(last_len), 32'd4);
    chk("s1_avail", 32'(bus.serial_data_out_available), 32'd0);

    // Scenario 2: FIFO empty
    s0 = n_strobe;
    p0 = int'(rd_ptr);
    xact(8'h1a, 8'h00, 8'h00, 8, r0, r1, r2);
    chk("s2_bytes", {8'h0, r0, r1, r2}, 32'h0);
    chk("s2_strobes", 32'(n_strobe - s0), 32'd0);
    chk("s2_rdptr", 32'(rd_ptr), 32'(p0));

    // Scenario 3: unknown command with data present
    push(8'h41);
    s0 = n_strobe;
    xact(8'h55, 8'ha5, 8'hff, 8, r0, r1, r2);
    chk("s3_bytes", {8'h0, r0, r1, r2}, 32'h0);
    chk("s3_strobes", 32'(n_strobe - s0), 32'd0);

    // Scenario 4: abort in the middle of the data byte
    push(8'h42);
    s0 = n_strobe;
    xact(8'h1a, 8'h00, 8'h00, 4, r0, r1, r2);
    chk("s4_b0", 32'(r0), 32'h00);
    chk("s4_b1", 32'(r1), 32'h80);
    chk("s4_strobes", 32'(n_strobe - s0), 32'd0);
    chk("s4_avail", 32'(bus.serial_data_out_available), 32'd1);
    xact(8'h1a, 8'h00, 8'h00, 8, r0, r1, r2);
    void'(exp_q.pop_front());
    chk("s4_retry_b1", 32'(r1), 32'h80);
    chk("s4_retry_b2", 32'(r2), 32'h41);
    chk("s4_retry_strobes", 32'(n_strobe - s0), 32'd1);

    // Scenario 5: back-to-back reads
    push(8'h43);
    s0 = n_strobe;
    xact(8'h1a, 8'h00, 8'h00, 8, r0, r1, r2);
    void'(exp_q.pop_front());
    chk("s5_first", 32'(r2), 32'h42);
    chk("s5_len1", 32'(last_len), 32'd4);
    xact(8'h1a, 8'h00, 8'h00, 8, r0, r1, r2);
    void'(exp_q.pop_front());
    chk("s5_second", 32'(r2), 32'h43);
    chk("s5_strobes", 32'(n_strobe - s0), 32'd2);
    chk("s5_gap_ge2", 32'(last_gap >= 2), 32'd1);
    chk("s5_avail", 32'(bus.serial_data_out_available), 32'd0);

    // Scenario 6: reset while the strobe is high
    push(8'h44);
    push(8'h45);
    bus.spi_ss_n = 1'b0;
    half();
    spi_byte(8'h1a, 8, r0);
    spi_byte(8'h00, 8, r1);
    spi_byte(8'h00, 7, r2);
    bus.spi_mosi = 1'b0;
    half();
    bus.spi_sck = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.serial_strobe_out;
    end
    chk("s6_strobe_seen", 32'(seen), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("s6_rst_strobe", 32'(bus.serial_strobe_out), 32'd0);
    chk("s6_rst_miso", 32'(bus.spi_miso), 32'd0);
    bus.spi_sck  = 1'b0;
    bus.spi_ss_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    void'(exp_q.pop_front());
    chk("s6_popped_once", 32'(rd_ptr), 32'(wr_ptr - 5'd1));
    s0 = n_strobe;
    xact(8'h1a, 8'h00, 8'h00, 8, r0, r1, r2);
    void'(exp_q.pop_front());
    chk("s6_post_b1", 32'(r1), 32'h80);
    chk("s6_post_b2", 32'(r2), 32'h45);
    chk("s6_post_strobes", 32'(n_strobe - s0), 32'd1);
    chk("s6_post_len", 32'(last_len), 32'd4);

    // Randomized transactions against the reference model
    for (int it = 0; it < 10; it++) begin
      npush = $urandom_range(0, 2);
      for (int k = 0; k < npush; k++)
        if (exp_q.size() < 14) push(8'($urandom));
      cmd = 8'h1a;
      if ($urandom_range(0, 2) == 0) begin
        cmd = 8'($urandom);
        if (cmd == 8'h1a) cmd = 8'h1b;
      end
      nb2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
      b1  = 8'($urandom);
      b2  = 8'($urandom);
      model(cmd, nb2, e0, e1, e2, pop);
      s0 = n_strobe;
      xact(cmd, b1, b2, nb2, r0, r1, r2);
      if (pop != 0) void'(exp_q.pop_front());
      chk($sformatf("rnd%0d_b0", it), 32'(r0), 32'(e0));
      chk($sformatf("rnd%0d_b1", it), 32'(r1), 32'(e1));
      if (nb2 == 8) chk($sformatf("rnd%0d_b2", it), 32'(r2), 32'(e2));
      chk($sformatf("rnd%0d_strobes", it), 32'(n_strobe - s0), 32'(pop));
      chk($sformatf("rnd%0d_avail", it), 32'(bus.serial_data_out_available),
          32'(exp_q.size() != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
